logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width; legal range >= 1.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  upstream offers operands this cycle.
REQ-005 Port: in_ready  out  1  block accepts operands this cycle; accept = in_valid & in_ready.
REQ-006 Port: a, b  in  WIDTH each  operands.
REQ-007 Port: op  in  3  operation select, sampled at accept.
REQ-008 Port: acc_mode  in  1  at accept, replaces operand a with the accumulator value.
REQ-009 Port: acc_clr  in  1  synchronous accumulator clear.
REQ-010 Port: out_valid  out  1  result available.
REQ-011 Port: out_ready  in  1  downstream takes result; emit = out_valid & out_ready.
REQ-012 Port: result  out  WIDTH  operation result, stable while out_valid & !out_ready.

Function
REQ-013 Op encoding: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS(b); bitwise over WIDTH bits.
REQ-014 Two-stage elastic pipeline: S1 registers a/b/op/acc_mode; S2 registers the computed result.
REQ-015 Latency: result of an accepted item appears with out_valid exactly 2 cycles after accept when not stalled.
REQ-016 Throughput: one item per cycle sustained while out_ready stays high.
REQ-017 S2 loads when S1 valid and (S2 empty or emit); S1 loads on accept; in_ready = !S1_valid | S1 advances this cycle.
REQ-018 Full stall: with out_ready low, at most 2 items are held; in_ready goes low; no item dropped, duplicated or reordered.
REQ-019 Evaluation occurs on the S1->S2 transfer; the operand a used is acc when acc_mode is set, else the registered a.
REQ-020 Accumulator (WIDTH bits) loads the computed result on every S1->S2 transfer, regardless of acc_mode.
REQ-021 acc_clr and a transfer in the same cycle: clear wins, acc <= 0; the transferring result itself is unaffected.
REQ-022 Back-to-back acc_mode items observe the accumulator value written by the immediately preceding transfer.
REQ-023 Inputs other than in_valid/out_ready/acc_clr are don't-care when not being accepted.

Reset
REQ-024 While rst is high: S1/S2 valid = 0, out_valid = 0, in_ready = 0, result = 0, acc = 0, flags = 0.
REQ-025 in_ready rises the first cycle after rst deasserts; reset mid-operation discards all in-flight items with no emit.

Configuration
REQ-026 Macro LOGIC_UNIT_FLAGS_EN defined: outputs out_zero (result == 0) and out_parity (XOR-reduce of result), registered with result, aligned to out_valid.
REQ-027 Macro LOGIC_UNIT_FLAGS_EN undefined: out_zero and out_parity ports and their logic are absent; all other behaviour identical.

Structure
REQ-028 Package logic_unit_pkg holds the op encoding constants/enum (OP_AND..OP_PASS) and the op field width.
REQ-029 Sub-module logic_unit_alu: purely combinational (a, b, op) -> result, instantiated once between S1 and S2.

Verification (WIDTH = 8)
REQ-030 a=0xF0, b=0x3C, op=AND then op=XOR on consecutive cycles, out_ready=1 -> results 0x30 then 0xCC, at accept+2 and accept+3.
REQ-031 out_ready=0, offer 3 items -> exactly 2 accepted, in_ready low; raise out_ready -> items emitted in order, third accepted.
REQ-032 acc_clr, then op=OR b=0x01 acc_mode=1, then op=OR b=0x80 acc_mode=1 back-to-back -> results 0x01, 0x81.
REQ-033 acc_clr asserted in the same cycle as a transfer computing 0x5A -> result 0x5A emitted, next acc_mode PASS-free OR with b=0 returns 0x00.
REQ-034 rst pulsed for 1 cycle with 2 items in flight -> no emit, out_valid=0 next cycle, acc=0, in_ready=1 one cycle after rst falls.
REQ-035 LOGIC_UNIT_FLAGS_EN: results 0x00 and 0x07 -> out_zero 1/0, out_parity 0/1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: operation encoding and op field width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_alu.sv
// Combinational bitwise operator: (a, b, op) -> result.
module logic_unit_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result
);

  // Bitwise operation select
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage elastic logic unit with accumulator feedback.
// Define LOGIC_UNIT_FLAGS_EN to add registered out_zero/out_parity outputs.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [OP_W-1:0]  s1_op_r;
  logic             s1_acc_mode_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_result_r;
  logic [WIDTH-1:0] acc_r;

  logic             emit_s;
  logic             s1_adv_s;
  logic             accept_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_result_s;

  // Handshake decode and operand-a selection
  always_comb begin
    emit_s   = s2_valid_r & out_ready;
    s1_adv_s = s1_valid_r & (~s2_valid_r | emit_s);
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = ~s1_valid_r | s1_adv_s;
    end
    accept_s = in_valid & in_ready_s;
    if (s1_acc_mode_r) begin
      alu_a_s = acc_r;
    end else begin
      alu_a_s = s1_a_r;
    end
  end

  logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a_s),
    .b      (s1_b_r),
    .op     (s1_op_r),
    .result (alu_result_s)
  );

  // Stage 1: operand capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_a_r        <= '0;
      s1_b_r        <= '0;
      s1_op_r       <= '0;
      s1_acc_mode_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r    <= 1'b1;
      s1_a_r        <= a;
      s1_b_r        <= b;
      s1_op_r       <= op;
      s1_acc_mode_r <= acc_mode;
    end else if (s1_adv_s) begin
      s1_valid_r    <= 1'b0;
    end
  end

  // Stage 2: result register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
    end else if (s1_adv_s) begin
      s2_valid_r  <= 1'b1;
      s2_result_r <= alu_result_s;
    end else if (emit_s) begin
      s2_valid_r  <= 1'b0;
    end
  end

  // Accumulator: clear has priority over the transfer load
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (acc_clr) begin
      acc_r <= '0;
    end else if (s1_adv_s) begin
      acc_r <= alu_result_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = s2_valid_r;
  assign result    = s2_result_r;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_r;
  logic parity_r;

  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Flags registered alongside the stage-2 result
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
    end else if (s1_adv_s) begin
      zero_r   <= (alu_result_s == '0);
      parity_r <= parity_f(alu_result_s);
    end
  end

  assign out_zero   = zero_r;
  assign out_parity = parity_r;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random traffic
// against an in-order item model (each item sees the previous item's result as acc).
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         acc_mode = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic         out_zero;
  logic         out_parity;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] acc_m = '0;
  int           n_chk = 0;
  int           n_bad = 0;
  int           cyc = 0;
  bit           lat_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return ~x;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return x ^ y;
      6: return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  // One clock cycle: drive at negedge, observe handshakes, update model, wait next negedge.
  task automatic step(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic [2:0] opi, input logic am, input logic clr,
                      input logic ordy, output logic acc_o);
    exp_t         e;
    logic [W-1:0] r;
    in_valid  = v;
    a         = ai;
    b         = bi;
    op        = opi;
    acc_mode  = am;
    acc_clr   = clr;
    out_ready = ordy;
    #1;
    acc_o = in_valid & in_ready;
    if (out_valid & out_ready) begin
      got_q.push_back(result);
      if (exp_q.size() == 0) begin
        check("spurious_emit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {24'd0, result}, {24'd0, e.res});
`ifdef LOGIC_UNIT_FLAGS_EN
        check("out_zero", {31'd0, out_zero}, {31'd0, (e.res == 8'h00)});
        check("out_parity", {31'd0, out_parity}, {31'd0, ^e.res});
`endif
        if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
      end
    end
    if (acc_o) begin
      r     = ref_op(int'(opi), am ? acc_m : ai, bi);
      acc_m = r;
      exp_q.push_back('{res: r, cyc: cyc});
    end
    if (clr) acc_m = '0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    logic d;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, d);
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   n;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // AND then XOR back-to-back with latency check
    lat_chk = 1'b1;
    step(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 8'hF0, 8'h3C, 3'd5, 1'b0, 1'b0, 1'b1, acc);
    drain();
    lat_chk = 1'b0;
    check("vec_and", {24'd0, got_q[got_q.size()-2]}, 32'h30);
    check("vec_xor", {24'd0, got_q[got_q.size()-1]}, 32'hCC);

    // Full stall: only two items held
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0, acc);
      n += int'(acc);
    end
    check("stall_accepts", n, 32'd2);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) begin
      step(1'b1, 8'h12, 8'h34, 3'd5, 1'b0, 1'b0, 1'b1, acc);
    end
    check("third_accepted", {31'd0, acc}, 32'd1);
    drain();

    // Accumulator chaining after clear
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 8'hAA, 8'h01, 3'd1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 8'hAA, 8'h80, 3'd1, 1'b1, 1'b0, 1'b1, acc);
    drain();
    check("acc_chain1", {24'd0, got_q[got_q.size()-2]}, 32'h01);
    check("acc_chain2", {24'd0, got_q[got_q.size()-1]}, 32'h81);

    // Clear in the same cycle as a transfer
    step(1'b1, 8'h00, 8'h5A, 3'd7, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, acc);
    drain();
    check("clr_xfer_res", {24'd0, got_q[got_q.size()-2]}, 32'h5A);
    check("clr_acc_zero", {24'd0, got_q[got_q.size()-1]}, 32'h00);

    // Reset with two items in flight
    step(1'b1, 8'h0F, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h0E, 8'h0E, 3'd1, 1'b0, 1'b0, 1'b0, acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    acc_m = '0;
    step(1'b1, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, acc);
    drain();
    check("acc_after_rst", {24'd0, got_q[got_q.size()-1]}, 32'h00);

    // Flag vectors (results 0x00 and 0x07)
    step(1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h00, 8'h07, 3'd7, 1'b0, 1'b0, 1'b1, acc);
    drain();

    // Random traffic with backpressure
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), W'($urandom), W'($urandom), 3'($urandom),
           1'($urandom), 1'b0, 1'($urandom_range(0, 9) < 7), acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
